// File: rtl/chan_scan_pkg.sv
// Shared constants, state type and mask helpers for the channel scan sequencer.
package chan_scan_pkg;

    localparam int NUM_CH = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_e;

    // Index of the lowest set bit; only meaningful when m != 0.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    function automatic logic higher_exists(input logic [NUM_CH-1:0] m,
                                           input logic [IDX_W-1:0]  idx);
        higher_exists = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i] && (i > int'(idx))) begin
                higher_exists = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/chan_next_pick.sv
// Combinational channel picker: next higher enabled channel after cur_idx and
// the lowest enabled channel of the mask.
module chan_next_pick
    import chan_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  cur_idx,
    output logic [IDX_W-1:0]  next_idx,
    output logic              next_found,
    output logic [IDX_W-1:0]  low_idx,
    output logic              any_set
);

    // Scanning from the top down lets the last hit win, i.e. the lowest match.
    always_comb begin
        next_idx   = '0;
        next_found = 1'b0;
        low_idx    = '0;
        any_set    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = IDX_W'(i);
                any_set = 1'b1;
                if (i > int'(cur_idx)) begin
                    next_idx   = IDX_W'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: walks the enabled channels of a latched mask, holding
// each for a programmable dwell, and drives a 3-to-8 decoder stage downstream.
module chan_scan_seq
    import chan_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [NUM_CH-1:0]   mask,
    input  logic [DWELL_W-1:0]  dwell,
    input  logic                continuous,
    output logic                busy,
    output logic [IDX_W-1:0]    dec_in,
    output logic                dec_en,
    output logic                ch_done,
    output logic                scan_done
);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                cont_q, cont_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [IDX_W-1:0]    dec_in_q, dec_in_d;
    logic                dec_en_q, dec_en_d;
    logic                ch_done_q, ch_done_d;
    logic                scan_done_q, scan_done_d;

    logic [IDX_W-1:0]    pick_next_idx;
    logic                pick_next_found;
    logic [IDX_W-1:0]    pick_low_idx;
    logic                pick_any;

    logic [DWELL_W-1:0]  load_in_cnt;
    logic [DWELL_W-1:0]  load_lat_cnt;

    // Channel entry request, resolved after the state case below.
    logic                load;
    logic [IDX_W-1:0]    load_idx;
    logic [DWELL_W-1:0]  load_cnt;
    logic [NUM_CH-1:0]   load_mask;

    chan_next_pick u_pick (
        .mask       (mask_q),
        .cur_idx    (dec_in_q),
        .next_idx   (pick_next_idx),
        .next_found (pick_next_found),
        .low_idx    (pick_low_idx),
        .any_set    (pick_any)
    );

    // Counter reload is eff_dwell-1, with a dwell of 0 treated as 1.
    assign load_in_cnt  = (dwell   == '0) ? '0 : dwell   - DWELL_W'(1);
    assign load_lat_cnt = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cont_d      = cont_q;
        cnt_d       = cnt_q;
        busy_d      = 1'b0;
        dec_in_d    = '0;
        dec_en_d    = 1'b0;
        ch_done_d   = 1'b0;
        scan_done_d = 1'b0;
        load        = 1'b0;
        load_idx    = '0;
        load_cnt    = '0;
        load_mask   = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (mask != '0) begin
                        mask_d    = mask;
                        dwell_d   = dwell;
                        cont_d    = continuous;
                        state_d   = DWELL;
                        load      = 1'b1;
                        load_idx  = lowest_idx(mask);
                        load_cnt  = load_in_cnt;
                        load_mask = mask;
                    end else begin
                        scan_done_d = 1'b1;
                    end
                end
            end

            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d       = cnt_q - DWELL_W'(1);
                    busy_d      = 1'b1;
                    dec_en_d    = 1'b1;
                    dec_in_d    = dec_in_q;
                    ch_done_d   = (cnt_q == DWELL_W'(1));
                    scan_done_d = (cnt_q == DWELL_W'(1)) && !pick_next_found;
                end else if (pick_next_found) begin
                    load      = 1'b1;
                    load_idx  = pick_next_idx;
                    load_cnt  = load_lat_cnt;
                    load_mask = mask_q;
                end else if (cont_q && pick_any) begin
                    load      = 1'b1;
                    load_idx  = pick_low_idx;
                    load_cnt  = load_lat_cnt;
                    load_mask = mask_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A one-cycle dwell is its own final cycle, so the done pulses are
        // already due on the entry cycle.
        if (load) begin
            cnt_d       = load_cnt;
            busy_d      = 1'b1;
            dec_en_d    = 1'b1;
            dec_in_d    = load_idx;
            ch_done_d   = (load_cnt == '0);
            scan_done_d = (load_cnt == '0) && !higher_exists(load_mask, load_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            dwell_q     <= '0;
            cont_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            dec_in_q    <= '0;
            dec_en_q    <= 1'b0;
            ch_done_q   <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cont_q      <= cont_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            dec_in_q    <= dec_in_d;
            dec_en_q    <= dec_en_d;
            ch_done_q   <= ch_done_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign busy      = busy_q;
    assign dec_in    = dec_in_q;
    assign dec_en    = dec_en_q;
    assign ch_done   = ch_done_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
// Bench for chan_scan_seq: a pass-level reference model predicts the output
// word of every cycle; a monitor on the falling edge compares it with the DUT.
module tb_chan_scan_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [7:0] dwell;
    logic       continuous;
    logic       busy;
    logic [2:0] dec_in;
    logic       dec_en;
    logic       ch_done;
    logic       scan_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Word layout: {busy, dec_en, dec_in[2:0], ch_done, scan_done}
    logic [6:0] exp_q[$];
    logic [6:0] plan_q[$];
    logic [6:0] cur_w = '0;
    logic [7:0] m_mask = '0;
    logic [7:0] m_dwell = '0;
    logic       m_cont = 1'b0;

    chan_scan_seq #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .continuous (continuous),
        .busy       (busy),
        .dec_in     (dec_in),
        .dec_en     (dec_en),
        .ch_done    (ch_done),
        .scan_done  (scan_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // One full pass over the latched mask, one word per dwell cycle.
    task automatic push_pass();
        int eff;
        int last;
        eff  = (m_dwell == 0) ? 1 : int'(m_dwell);
        last = 0;
        for (int c = 0; c < 8; c++) begin
            if (m_mask[c]) last = c;
        end
        for (int c = 0; c < 8; c++) begin
            if (m_mask[c]) begin
                for (int k = 0; k < eff; k++) begin
                    plan_q.push_back({1'b1, 1'b1, 3'(c), (k == eff - 1),
                                      (k == eff - 1) && (c == last)});
                end
            end
        end
    endtask

    always @(posedge clk) begin : model
        logic [6:0] nxt;
        nxt = '0;
        if (!rst_n) begin
            plan_q.delete();
            m_mask  = '0;
            m_dwell = '0;
            m_cont  = 1'b0;
        end else if (!cur_w[5]) begin
            if (start && !stop) begin
                if (mask == 8'h00) begin
                    nxt = 7'b000_0001;
                end else begin
                    m_mask  = mask;
                    m_dwell = dwell;
                    m_cont  = continuous;
                    plan_q.delete();
                    push_pass();
                    nxt = plan_q.pop_front();
                end
            end
        end else begin
            if (stop) begin
                plan_q.delete();
            end else begin
                if (plan_q.size() == 0 && m_cont) push_pass();
                if (plan_q.size() != 0) nxt = plan_q.pop_front();
            end
        end
        cur_w = nxt;
        exp_q.push_back(nxt);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [6:0] e;
        logic [6:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {busy, dec_en, dec_in, ch_done, scan_done};
            n_checks++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_out t=%0t busy/en/idx/ch/scan act=%b exp=%b",
                          $time, a, e);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks enter and leave 2 time units after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start(input logic [7:0] m, input logic [7:0] d, input logic c);
        start      = 1'b1;
        mask       = m;
        dwell      = d;
        continuous = c;
        step(1);
        start      = 1'b0;
        mask       = 8'($urandom);
        dwell      = 8'($urandom);
        continuous = 1'($urandom);
    endtask

    task automatic async_reset_check();
        logic [6:0] a;
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        a = {busy, dec_en, dec_in, ch_done, scan_done};
        n_checks++;
        if (a === 7'b0) n_pass++;
        else $display("FAIL async_reset act=%b exp=%b", a, 7'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        mask       = '0;
        dwell      = '0;
        continuous = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(3);

        // Basic three-channel pass, then input noise during the scan.
        do_start(8'b0010_0101, 8'd3, 1'b0);
        step(12);

        // Single channel, continuous, dwell 0, then abort.
        do_start(8'h80, 8'd0, 1'b1);
        step(5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);

        // Empty mask.
        do_start(8'h00, 8'd2, 1'b0);
        step(3);

        // Full mask, stop on the second cycle of channel 3.
        do_start(8'hFF, 8'd4, 1'b0);
        step(13);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(4);

        // Restart attempt mid-scan is ignored.
        do_start(8'b0010_0101, 8'd2, 1'b0);
        step(2);
        start = 1'b1;
        mask  = 8'h01;
        step(1);
        start = 1'b0;
        step(8);

        // Start and stop together in idle.
        start = 1'b1;
        stop  = 1'b1;
        mask  = 8'h0F;
        dwell = 8'd1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(3);

        // Asynchronous reset mid-dwell, then stay idle without start.
        do_start(8'hFF, 8'd5, 1'b1);
        step(3);
        async_reset_check();
        step(5);

        // Continuous scan with a long dwell, stop landing on a final cycle.
        do_start(8'h12, 8'd9, 1'b1);
        step(17);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(3);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 40) == 0);
            mask       = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dwell      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 12))
                                                     : 8'($urandom_range(0, 4));
            continuous = ($urandom_range(0, 3) == 0);
            step(1);
        end

        start = 1'b0;
        stop  = 1'b1;
        step(2);
        stop  = 1'b0;
        step(2);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
